// File: rtl/exc_pkg.sv
// Shared types and cause-code constants for the exception controller.
package exc_pkg;

    localparam int ESTATUS_W = 4;

    localparam logic [3:0] ESTAT_NONE     = 4'h0;
    localparam logic [3:0] ESTAT_IRQ_BASE = 4'h1;
    localparam logic [3:0] ESTAT_BADOP    = 4'hE;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } exc_state_e;

endpackage

// File: rtl/irq_edge_detect.sv
// Rising-edge detector for the interrupt lines; EXC_IRQ_SYNC_EN inserts a
// two-flop synchronizer ahead of the edge history register.
module irq_edge_detect
    import exc_pkg::*;
#(
    parameter int NIRQ = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NIRQ-1:0] irq_i,
    output logic [NIRQ-1:0] rise_o
);

    logic [NIRQ-1:0] src_s;
    logic [NIRQ-1:0] irq_q;

`ifdef EXC_IRQ_SYNC_EN
    logic [NIRQ-1:0] sync1_q;
    logic [NIRQ-1:0] sync2_q;

    // Two-stage synchronizer for lines that may be asynchronous to clk.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq_i;
            sync2_q <= sync1_q;
        end
    end

    assign src_s = sync2_q;
`else
    assign src_s = irq_i;
`endif

    // Previous-cycle history of the (possibly synchronized) lines.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_q <= '0;
        end else begin
            irq_q <= src_s;
        end
    end

    assign rise_o = src_s & ~irq_q;

endmodule

// File: rtl/exc_controller.sv
// Exception source: latches interrupt edges and invalid-opcode flags, raises
// Exc/EStatus to the datapath and masks new requests until ERet.
// Optional macro EXC_IRQ_SYNC_EN adds an irq synchronizer (see irq_edge_detect).
module exc_controller #(
    parameter int NIRQ      = 4,
    parameter int ESTATUS_W = exc_pkg::ESTATUS_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NIRQ-1:0]      irq,
    input  logic [NIRQ-1:0]      irq_mask,
    input  logic                 bad_instr,
    input  logic                 ERet,
    input  logic                 ExcAck,
    output logic                 Exc,
    output logic [ESTATUS_W-1:0] EStatus,
    output logic                 in_handler
);
    import exc_pkg::*;

    if (NIRQ < 1 || NIRQ > 13) begin : g_bad_nirq
        $error("exc_controller: NIRQ must be in 1..13");
    end
    if (ESTATUS_W < 4) begin : g_bad_estatus_w
        $error("exc_controller: ESTATUS_W must be at least 4");
    end

    exc_state_e           state_q, state_d;
    logic [NIRQ-1:0]      pend_q, pend_d, rise_s, elig_s, irq_win_s;
    logic                 pend_bad_q, pend_bad_d;
    logic [NIRQ:0]        win_q, win_d, sel_win_s, clr_s;
    logic [ESTATUS_W-1:0] estatus_q, estatus_d, sel_code_s, irq_code_s;
    logic                 exc_q, exc_d, in_handler_q, in_handler_d;
    logic                 sel_any_s, found_s;

    irq_edge_detect #(.NIRQ(NIRQ)) u_edge (
        .clk    (clk),
        .reset  (reset),
        .irq_i  (irq),
        .rise_o (rise_s)
    );

    // Winner selection: pend_bad first, then lowest-numbered unmasked line.
    always_comb begin
        elig_s     = pend_q & irq_mask;
        irq_code_s = ESTATUS_W'(ESTAT_NONE);
        irq_win_s  = '0;
        found_s    = 1'b0;
        for (int i = 0; i < NIRQ; i++) begin
            if (elig_s[i] && !found_s) begin
                irq_code_s   = ESTATUS_W'(ESTAT_IRQ_BASE) + ESTATUS_W'(i);
                irq_win_s[i] = 1'b1;
                found_s      = 1'b1;
            end else begin
                irq_win_s[i] = 1'b0;
            end
        end
        if (pend_bad_q) begin
            sel_code_s = ESTATUS_W'(ESTAT_BADOP);
            sel_win_s  = {1'b1, {NIRQ{1'b0}}};
        end else begin
            sel_code_s = irq_code_s;
            sel_win_s  = {1'b0, irq_win_s};
        end
        sel_any_s = pend_bad_q | found_s;
    end

    // FSM next state, output next values and pending-bit update.
    always_comb begin
        state_d      = state_q;
        exc_d        = exc_q;
        estatus_d    = estatus_q;
        in_handler_d = in_handler_q;
        win_d        = win_q;
        clr_s        = '0;
        case (state_q)
            IDLE: begin
                if (sel_any_s) begin
                    state_d   = REQ;
                    exc_d     = 1'b1;
                    estatus_d = sel_code_s;
                    win_d     = sel_win_s;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (ExcAck) begin
                    state_d      = SERVICE;
                    exc_d        = 1'b0;
                    in_handler_d = 1'b1;
                    clr_s        = win_q;
                end else begin
                    state_d = REQ;
                end
            end
            SERVICE: begin
                if (ERet) begin
                    state_d      = IDLE;
                    in_handler_d = 1'b0;
                    estatus_d    = ESTATUS_W'(ESTAT_NONE);
                    win_d        = '0;
                end else begin
                    state_d = SERVICE;
                end
            end
            default: begin
                state_d      = IDLE;
                exc_d        = 1'b0;
                estatus_d    = ESTATUS_W'(ESTAT_NONE);
                in_handler_d = 1'b0;
                win_d        = '0;
            end
        endcase
        // A fresh edge on the line being acknowledged survives the clear.
        pend_d     = (pend_q & ~clr_s[NIRQ-1:0]) | rise_s;
        pend_bad_d = (pend_bad_q & ~clr_s[NIRQ]) | bad_instr;
    end

    // State, pending and registered-output flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            pend_q       <= '0;
            pend_bad_q   <= 1'b0;
            win_q        <= '0;
            exc_q        <= 1'b0;
            estatus_q    <= '0;
            in_handler_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            pend_bad_q   <= pend_bad_d;
            win_q        <= win_d;
            exc_q        <= exc_d;
            estatus_q    <= estatus_d;
            in_handler_q <= in_handler_d;
        end
    end

    assign Exc        = exc_q;
    assign EStatus    = estatus_q;
    assign in_handler = in_handler_q;

endmodule

// File: tb/tb_exc_controller.sv
// Directed self-checking bench for exc_controller.
module tb_exc_controller;

`ifdef EXC_IRQ_SYNC_EN
    localparam int EXTRA = 2;
`else
    localparam int EXTRA = 0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] irq, irq_mask;
    logic       bad_instr, ERet, ExcAck;
    logic       Exc, in_handler;
    logic [3:0] EStatus;

    int errors = 0;
    int checks = 0;

    exc_controller #(.NIRQ(4), .ESTATUS_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .irq        (irq),
        .irq_mask   (irq_mask),
        .bad_instr  (bad_instr),
        .ERet       (ERet),
        .ExcAck     (ExcAck),
        .Exc        (Exc),
        .EStatus    (EStatus),
        .in_handler (in_handler)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; irq = 4'h0; irq_mask = 4'hF;
        bad_instr = 1'b0; ERet = 1'b0; ExcAck = 1'b0;
        repeat (2) tick();
        checks++; if (Exc !== 1'b0) begin errors++; $display("FAIL reset_exc: got %0b want 0", Exc); end
        checks++; if (EStatus !== 4'h0) begin errors++; $display("FAIL reset_estatus: got %0h want 0", EStatus); end
        checks++; if (in_handler !== 1'b0) begin errors++; $display("FAIL reset_in_handler: got %0b want 0", in_handler); end
        reset = 1'b1;
        repeat (3) tick();
        checks++; if (Exc !== 1'b0) begin errors++; $display("FAIL reset_idle_exc: got %0b want 0", Exc); end
    endtask

    task automatic test_basic();
        irq[2] = 1'b1;
        repeat (1 + EXTRA) tick();
        checks++; if (Exc !== 1'b0) begin errors++; $display("FAIL basic_early: got %0b want 0", Exc); end
        tick();
        checks++; if (Exc !== 1'b1) begin errors++; $display("FAIL basic_exc: got %0b want 1", Exc); end
        checks++; if (EStatus !== 4'h3) begin errors++; $display("FAIL basic_code: got %0h want 3", EStatus); end
        for (int n = 0; n < 4; n++) begin
            tick();
            checks++; if (Exc !== 1'b1 || EStatus !== 4'h3) begin errors++; $display("FAIL basic_hold: got %0b/%0h want 1/3", Exc, EStatus); end
        end
        ExcAck = 1'b1; tick(); ExcAck = 1'b0;
        checks++; if (Exc !== 1'b0) begin errors++; $display("FAIL basic_ack_exc: got %0b want 0", Exc); end
        checks++; if (in_handler !== 1'b1) begin errors++; $display("FAIL basic_ack_inh: got %0b want 1", in_handler); end
        checks++; if (EStatus !== 4'h3) begin errors++; $display("FAIL basic_svc_code: got %0h want 3", EStatus); end
        ERet = 1'b1; tick(); ERet = 1'b0;
        checks++; if (in_handler !== 1'b0 || EStatus !== 4'h0) begin errors++; $display("FAIL basic_eret: got %0b/%0h want 0/0", in_handler, EStatus); end
        irq = 4'h0;
        repeat (3) tick();
        checks++; if (Exc !== 1'b0) begin errors++; $display("FAIL basic_no_retrig: got %0b want 0", Exc); end
    endtask

    task automatic test_priority();
        logic [3:0] exp_codes [3] = '{4'hE, 4'h2, 4'h4};
        irq[1] = 1'b1; irq[3] = 1'b1; bad_instr = 1'b1;
        tick();
        bad_instr = 1'b0;
        for (int n = 0; n < 10; n++) begin
            if (Exc === 1'b1) break;
            tick();
        end
        checks++; if (Exc !== 1'b1) begin errors++; $display("FAIL prio_timeout: got %0b want 1", Exc); end
        for (int k = 0; k < 3; k++) begin
            checks++; if (EStatus !== exp_codes[k]) begin errors++; $display("FAIL prio_code%0d: got %0h want %0h", k, EStatus, exp_codes[k]); end
            ExcAck = 1'b1; tick(); ExcAck = 1'b0;
            checks++; if (Exc !== 1'b0 || in_handler !== 1'b1) begin errors++; $display("FAIL prio_ack%0d: got %0b/%0b want 0/1", k, Exc, in_handler); end
            ERet = 1'b1; tick(); ERet = 1'b0;
            checks++; if (Exc !== 1'b0 || in_handler !== 1'b0) begin errors++; $display("FAIL prio_gap%0d: got %0b/%0b want 0/0", k, Exc, in_handler); end
            tick();
            if (k < 2) begin
                checks++; if (Exc !== 1'b1) begin errors++; $display("FAIL prio_next%0d: got %0b want 1", k, Exc); end
            end else begin
                checks++; if (Exc !== 1'b0) begin errors++; $display("FAIL prio_done: got %0b want 0", Exc); end
            end
        end
        irq = 4'h0;
        tick();
    endtask

    task automatic test_level_hold();
        int highs = 0;
        irq[0] = 1'b1;
        for (int n = 0; n < 10; n++) begin
            if (Exc === 1'b1) break;
            tick();
        end
        checks++; if (Exc !== 1'b1 || EStatus !== 4'h1) begin errors++; $display("FAIL level_req: got %0b/%0h want 1/1", Exc, EStatus); end
        ExcAck = 1'b1; tick(); ExcAck = 1'b0;
        ERet = 1'b1; tick(); ERet = 1'b0;
        for (int n = 0; n < 14; n++) begin
            tick();
            if (Exc === 1'b1) highs++;
        end
        checks++; if (highs !== 0) begin errors++; $display("FAIL level_retrigger: got %0d want 0 high cycles", highs); end
        irq = 4'h0;
        tick();
    endtask

    task automatic test_mask();
        int highs = 0;
        irq[2] = 1'b1; tick(); irq[2] = 1'b0;
        for (int n = 0; n < 10; n++) begin
            if (Exc === 1'b1) break;
            tick();
        end
        checks++; if (Exc !== 1'b1 || EStatus !== 4'h3) begin errors++; $display("FAIL mask_first: got %0b/%0h want 1/3", Exc, EStatus); end
        ExcAck = 1'b1; tick(); ExcAck = 1'b0;
        irq_mask = 4'b1101; irq[1] = 1'b1;
        repeat (4) tick();
        ERet = 1'b1; tick(); ERet = 1'b0;
        checks++; if (in_handler !== 1'b0) begin errors++; $display("FAIL mask_eret: got %0b want 0", in_handler); end
        for (int n = 0; n < 5; n++) begin
            tick();
            if (Exc === 1'b1) highs++;
        end
        checks++; if (highs !== 0) begin errors++; $display("FAIL mask_blocked: got %0d want 0 high cycles", highs); end
        irq_mask = 4'hF;
        tick();
        checks++; if (Exc !== 1'b1 || EStatus !== 4'h2) begin errors++; $display("FAIL mask_unmask: got %0b/%0h want 1/2", Exc, EStatus); end
        ExcAck = 1'b1; tick(); ExcAck = 1'b0;
        ERet = 1'b1; tick(); ERet = 1'b0;
        irq = 4'h0;
        tick();
    endtask

    task automatic test_ignored();
        ExcAck = 1'b1; ERet = 1'b1; tick(); ExcAck = 1'b0; ERet = 1'b0;
        checks++; if (Exc !== 1'b0 || in_handler !== 1'b0) begin errors++; $display("FAIL ignored_ack: got %0b/%0b want 0/0", Exc, in_handler); end
    endtask

    task automatic test_async_reset();
        int highs = 0;
        irq[3] = 1'b1;
        for (int n = 0; n < 10; n++) begin
            if (Exc === 1'b1) break;
            tick();
        end
        checks++; if (Exc !== 1'b1 || EStatus !== 4'h4) begin errors++; $display("FAIL areset_req: got %0b/%0h want 1/4", Exc, EStatus); end
        irq = 4'h0;
        tick();
        #2 reset = 1'b0;
        #1;
        checks++; if (Exc !== 1'b0 || EStatus !== 4'h0) begin errors++; $display("FAIL areset_immediate: got %0b/%0h want 0/0", Exc, EStatus); end
        #2 reset = 1'b1;
        for (int n = 0; n < 8; n++) begin
            tick();
            if (Exc === 1'b1) highs++;
        end
        checks++; if (highs !== 0) begin errors++; $display("FAIL areset_no_exc: got %0d want 0 high cycles", highs); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_priority();
        test_level_hold();
        test_mask();
        test_ignored();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
